// File: rtl/uart_program_loader.sv
`timescale 1ns/1ps
// UART (8N1) boot loader: receives a length-prefixed little-endian image, writes it to instruction
// ROM and releases the CPU reset once complete. Define LOADER_CHECKSUM_EN for a trailing sum byte.
module uart_program_loader #(
  parameter int CLK_PER_BIT = 868,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  uart_rx,
  output logic                  rom_wren,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic [31:0]           rom_write_data,
  output logic                  cpu_reset_n,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [32:0]   DEPTH     = 33'(1) << ADDR_WIDTH;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] ST_RX_LEN = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_DONE   = 3'd2;
  localparam logic [2:0] ST_ERROR  = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHECKSUM = 3'd4;
  localparam logic [2:0] ST_AFTER    = ST_CHECKSUM;
`else
  localparam logic [2:0] ST_AFTER    = ST_DONE;
`endif

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic [1:0]    r_rx_sync;
  logic          w_rx;
  logic [1:0]    r_rx_state;
  logic [CW-1:0] r_bit_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_rx_shift;
  logic          r_rx_valid;
  logic          r_rx_ferr;

  assign w_rx = r_rx_sync[1];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_sync  <= 2'b11;
      r_rx_state <= RX_IDLE;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], uart_rx};
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_rx) begin
            r_rx_state <= RX_START;
            r_bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (r_bit_cnt == HALF_LAST) begin
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            // A start bit that is high again by mid-bit was only a glitch.
            r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= {w_rx, r_rx_shift[7:1]};
            r_bit_idx  <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        default: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_rx_valid <= w_rx;
            r_rx_ferr  <= !w_rx;
            r_rx_state <= RX_IDLE;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  logic [2:0]            r_state;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_len_buf;
  logic [23:0]           r_word_buf;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic [ADDR_WIDTH-1:0] r_last_idx;
  logic                  r_wren;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [31:0]           r_wdata;
  logic                  r_cpu_rst_n;
  logic [31:0]           w_len_full;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_sum;
`endif

  assign w_len_full = {r_rx_shift, r_len_buf};

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_RX_LEN;
      r_byte_cnt  <= '0;
      r_len_buf   <= '0;
      r_word_buf  <= '0;
      r_word_idx  <= '0;
      r_last_idx  <= '0;
      r_wren      <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_cpu_rst_n <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_wren <= 1'b0;
      case (r_state)
        ST_RX_LEN: begin
          if (r_rx_ferr) begin
            r_state <= ST_ERROR;
          end else if (r_rx_valid) begin
            r_len_buf  <= {r_rx_shift, r_len_buf[23:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= r_sum + r_rx_shift;
`endif
            if (r_byte_cnt == 2'd3) begin
              r_last_idx <= ADDR_WIDTH'(w_len_full - 32'd1);
              if ({1'b0, w_len_full} > DEPTH) r_state <= ST_ERROR;
              else if (w_len_full == 32'd0)   r_state <= ST_AFTER;
              else                            r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (r_rx_ferr) begin
            r_state <= ST_ERROR;
          end else if (r_rx_valid) begin
            r_word_buf <= {r_rx_shift, r_word_buf[23:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= r_sum + r_rx_shift;
`endif
            if (r_byte_cnt == 2'd3) begin
              r_wren     <= 1'b1;
              r_waddr    <= r_word_idx;
              r_wdata    <= {r_rx_shift, r_word_buf};
              r_word_idx <= r_word_idx + ADDR_WIDTH'(1);
              if (r_word_idx == r_last_idx) r_state <= ST_AFTER;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECKSUM: begin
          if (r_rx_ferr)       r_state <= ST_ERROR;
          else if (r_rx_valid) r_state <= (r_rx_shift == r_sum) ? ST_DONE : ST_ERROR;
        end
`endif
        ST_DONE:  r_cpu_rst_n <= 1'b1;
        ST_ERROR: r_cpu_rst_n <= 1'b0;
        default:  r_state     <= ST_ERROR;
      endcase
    end
  end

  assign rom_wren       = r_wren;
  assign rom_address    = r_waddr;
  assign rom_write_data = r_wdata;
  assign cpu_reset_n    = r_cpu_rst_n;
  assign load_done      = (r_state == ST_DONE);
  assign load_error     = (r_state == ST_ERROR);

endmodule

// File: tb/tb_uart_program_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_program_loader: randomized images, reference model fills the write queue.
module tb_uart_program_loader;
  localparam int CPB   = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          uart_rx = 1'b1;
  logic          rom_wren;
  logic [AW-1:0] rom_address;
  logic [31:0]   rom_write_data;
  logic          cpu_reset_n;
  logic          load_done;
  logic          load_error;

  always #5 clk = ~clk;

  uart_program_loader #(.CLK_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .uart_rx        (uart_rx),
    .rom_wren       (rom_wren),
    .rom_address    (rom_address),
    .rom_write_data (rom_write_data),
    .cpu_reset_n    (cpu_reset_n),
    .load_done      (load_done),
    .load_error     (load_error)
  );

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  // Monitor: compares every ROM strobe against the scoreboard and watches CPU release timing.
  wr_t  mon_e;
  logic prev_wren = 1'b0;
  int   done_age = 0;
  int   err_age  = 0;

  always @(negedge clk) begin
    if (rom_wren === 1'b1) begin
      $display("rom write addr=0x%0h data=0x%08h", rom_address, rom_write_data);
      if (prev_wren === 1'b1) begin
        n_checks++;
        $display("FAIL wren_pulse: actual=2+ cycles required=1 cycle");
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h required=no write",
                 rom_address, rom_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("rom_address", 64'(rom_address), 64'(mon_e.addr));
        check("rom_write_data", 64'(rom_write_data), 64'(mon_e.data));
      end
    end
    prev_wren = rom_wren;
    if (load_done === 1'b1) done_age++; else done_age = 0;
    if (done_age == 1) check("cpu_reset_n_at_done_entry", 64'(cpu_reset_n), 64'(0));
    if (done_age == 2) check("cpu_reset_n_after_done", 64'(cpu_reset_n), 64'(1));
    if (load_error === 1'b1) err_age++; else err_age = 0;
    if (err_age == 2) check("cpu_reset_n_on_error", 64'(cpu_reset_n), 64'(0));
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cycles(CPB);
    end
    uart_rx = !bad_stop;
    wait_cycles(CPB);
    uart_rx = 1'b1;
    wait_cycles(CPB * (bad_stop ? 3 : int'($urandom_range(0, 2))));
  endtask

  task automatic glitch();
    uart_rx = 1'b0;
    wait_cycles(1);
    uart_rx = 1'b1;
    wait_cycles(3 * CPB);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    uart_rx = 1'b1;
    wait_cycles(3);
    exp_q.delete();
    reset_n = 1'b1;
    wait_cycles(4);
  endtask

  // Image as a byte stream: 4-byte LE count, LE words, optional checksum (+delta to corrupt it).
  task automatic build(input int n_field, input wq_t w, input int delta, output bq_t s);
    logic [31:0] nf;
    logic [31:0] wd;
    logic [7:0]  sum;
    s.delete();
    nf  = 32'(n_field);
    sum = 8'd0;
    for (int i = 0; i < 4; i++) s.push_back(nf[8*i +: 8]);
    foreach (w[k]) begin
      wd = w[k];
      for (int i = 0; i < 4; i++) s.push_back(wd[8*i +: 8]);
    end
    if (CK) begin
      foreach (s[k]) sum = sum + s[k];
      s.push_back(sum + 8'(delta));
    end
  endtask

  // Reference: decides outcome of a byte stream and queues the writes it should cause.
  task automatic model(input bq_t s, input int bad, output bit done, output bit err);
    longint n;
    int     p;
    wr_t    t;
    logic [7:0] sum;
    done = 1'b0;
    err  = 1'b0;
    n    = 0;
    sum  = 8'd0;
    for (int i = 0; i < s.size(); i++) begin
      if (i == bad) begin err = 1'b1; return; end
      if (i < 4) begin
        n   = n + (longint'(s[i]) << (8 * i));
        sum = sum + s[i];
        if (i == 3) begin
          if (n > DEPTH) begin err = 1'b1; return; end
          if (n == 0 && !CK) begin done = 1'b1; return; end
        end
      end else if (longint'(i - 4) < 4 * n) begin
        p   = i - 4;
        sum = sum + s[i];
        if (p % 4 == 3) begin
          t.addr = AW'(p / 4);
          t.data = {s[i], s[i-1], s[i-2], s[i-3]};
          exp_q.push_back(t);
          if (longint'(p / 4) == n - 1 && !CK) begin done = 1'b1; return; end
        end
      end else begin
        if (s[i] == sum) done = 1'b1; else err = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_scenario(input string name, input bq_t s, input int bad, input int limit);
    bq_t sent;
    bit  ed, ee;
    do_reset();
    check({name, "/reset_rom_wren"}, 64'(rom_wren), 64'(0));
    check({name, "/reset_cpu_reset_n"}, 64'(cpu_reset_n), 64'(0));
    check({name, "/reset_load_done"}, 64'(load_done), 64'(0));
    check({name, "/reset_load_error"}, 64'(load_error), 64'(0));
    check({name, "/reset_rom_address"}, 64'(rom_address), 64'(0));
    sent.delete();
    for (int i = 0; i < s.size() && i < limit; i++) sent.push_back(s[i]);
    model(sent, bad, ed, ee);
    for (int i = 0; i < sent.size(); i++) begin
      if ($urandom_range(0, 4) == 0) glitch();
      send_byte(sent[i], i == bad);
    end
    wait_cycles(4 * CPB);
    check({name, "/load_done"}, 64'(load_done), 64'(ed));
    check({name, "/load_error"}, 64'(load_error), 64'(ee));
    check({name, "/cpu_reset_n"}, 64'(cpu_reset_n), 64'(ed));
    check({name, "/pending_writes"}, 64'(exp_q.size()), 64'(0));
    $display("scenario %s: sent %0d bytes, expected done=%0d error=%0d", name, sent.size(), ed, ee);
  endtask

  initial begin
    bq_t s;
    wq_t w;
    int  n;

    w.delete(); w.push_back(32'h0000_0013); w.push_back(32'hDEAD_BEEF);
    build(2, w, 0, s);
    glitch();
    run_scenario("two_words", s, -1, 1000);

    w.delete();
    build(0, w, 0, s);
    for (int i = 0; i < 4; i++) s.push_back(8'($urandom));
    run_scenario("len_zero", s, -1, 1000);

    build(17, w, 0, s);
    for (int i = 0; i < 4; i++) s.push_back(8'($urandom));
    run_scenario("len_over_depth", s, -1, 1000);

    w.delete(); w.push_back($urandom); w.push_back($urandom);
    build(2, w, 0, s);
    run_scenario("stop_error_word1", s, 9, 1000);

    w.delete(); for (int i = 0; i < 3; i++) w.push_back($urandom);
    build(3, w, 0, s);
    run_scenario("reset_mid_load", s, -1, 10);

    w.delete(); w.push_back(32'hCAFE_F00D);
    build(1, w, 0, s);
    run_scenario("reload_after_reset", s, -1, 1000);

    w.delete(); for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
    build(DEPTH, w, 0, s);
    run_scenario("full_depth", s, -1, 1000);

`ifdef LOADER_CHECKSUM_EN
    w.delete(); w.push_back(32'h0102_0304);
    build(1, w, 0, s);
    run_scenario("checksum_good", s, -1, 1000);
    build(1, w, 1, s);
    run_scenario("checksum_bad", s, -1, 1000);
`endif

    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 6));
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      build(n, w, int'($urandom_range(0, 1)), s);
      run_scenario("random", s, -1, 1000);
    end

    wait_cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
